// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg -- definitions shared by the serial pattern transmitter and the
// 1101 sequence detector benches.
//   seq_state_e   : transmitter FSM states (IDLE, SHIFT, GAP, DONE)
//   SEQ_1101      : reference pattern for the 1101 detector
//   SEQ_1101_LEN  : length of that reference pattern
//   len_width()   : width of a pattern-length field able to hold 0..pat_w
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [3:0] SEQ_1101     = 4'b1101;
  localparam int         SEQ_1101_LEN = 4;

  // Bits needed to encode a length in the inclusive range 0..pat_w
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen -- bit-serial pattern transmitter.
// Captures a pattern of len_in bits and sends it MSB-first on y, one bit per
// clock, repeated rep_in+1 times with GAP_CYC idle cycles between sends.
// All outputs are registered.
//
// Build option: define SEQ_GEN_PARITY_EN to append an even-parity bit after
// the data bits of every repetition.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   transfer request, honoured only in IDLE
//   abort    in   synchronous cancel of an active transfer
//   pat_in   in   pattern, low len_in bits used
//   len_in   in   pattern length, valid 1..PAT_W
//   rep_in   in   extra repetitions (total sends = rep_in+1)
//   y        out  serial data
//   y_valid  out  y carries a pattern (or parity) bit
//   busy     out  transfer in progress (state != IDLE)
//   done     out  one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [PAT_W-1:0]              pat_in,
  input  logic [len_width(PAT_W)-1:0]   len_in,
  input  logic [REP_W-1:0]              rep_in,
  output logic                          y,
  output logic                          y_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int                LEN_W    = len_width(PAT_W);
  localparam int                GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(PAT_W);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  seq_state_e        state_r;
  logic [PAT_W-1:0]  pat_r;      // captured pattern, MSB-aligned
  logic [PAT_W-1:0]  sh_r;       // bits still to send, next one at the top
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx_r;      // remaining bits after the one on y
  logic [REP_W-1:0]  rep_r;
  logic [GAP_W-1:0]  gap_r;
  logic              accept_s;
  logic [PAT_W-1:0]  aligned_s;

`ifdef SEQ_GEN_PARITY_EN
  logic              par_r;        // even parity of the captured bits
  logic              par_phase_r;  // y currently carries the parity bit

  // Even parity over a word; bits outside the pattern are already zero
  function automatic logic even_parity(input logic [PAT_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Start qualification and MSB alignment; abort in IDLE suppresses start.
  // Aligning pushes unused high bits out, so the pattern lands zero-padded.
  always_comb begin
    accept_s  = start && !abort && (len_in != {LEN_W{1'b0}}) && (len_in <= MAX_LEN);
    aligned_s = pat_in << (MAX_LEN - len_in);
  end

  // Transfer FSM: state, shift datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pat_r   <= {PAT_W{1'b0}};
      sh_r    <= {PAT_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      idx_r   <= {LEN_W{1'b0}};
      rep_r   <= {REP_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
      y       <= 1'b0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_r       <= 1'b0;
      par_phase_r <= 1'b0;
`endif
    end else if (abort && (state_r != IDLE)) begin
      state_r <= IDLE;
      idx_r   <= {LEN_W{1'b0}};
      rep_r   <= {REP_W{1'b0}};
      gap_r   <= {GAP_W{1'b0}};
      y       <= 1'b0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_phase_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            state_r <= SHIFT;
            pat_r   <= aligned_s;
            sh_r    <= aligned_s << 1;
            len_r   <= len_in;
            idx_r   <= len_in - LEN_W'(1);
            rep_r   <= rep_in;
            y       <= aligned_s[PAT_W-1];
            y_valid <= 1'b1;
            busy    <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            par_r       <= even_parity(aligned_s);
            par_phase_r <= 1'b0;
`endif
          end else begin
            y       <= 1'b0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        SHIFT: begin
          if (idx_r != {LEN_W{1'b0}}) begin
            y     <= sh_r[PAT_W-1];
            sh_r  <= sh_r << 1;
            idx_r <= idx_r - LEN_W'(1);
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (!par_phase_r) begin
            y           <= par_r;
            par_phase_r <= 1'b1;
          end
`endif
          else begin
            // Last bit of this repetition is on y now
`ifdef SEQ_GEN_PARITY_EN
            par_phase_r <= 1'b0;
`endif
            if (rep_r != {REP_W{1'b0}}) begin
              rep_r <= rep_r - REP_W'(1);
              if (GAP_CYC > 0) begin
                state_r <= GAP;
                gap_r   <= GAP_LOAD;
                y       <= 1'b0;
                y_valid <= 1'b0;
              end else begin
                y     <= pat_r[PAT_W-1];
                sh_r  <= pat_r << 1;
                idx_r <= len_r - LEN_W'(1);
              end
            end else begin
              state_r <= DONE;
              y       <= 1'b0;
              y_valid <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_r == {GAP_W{1'b0}}) begin
            state_r <= SHIFT;
            y       <= pat_r[PAT_W-1];
            y_valid <= 1'b1;
            sh_r    <= pat_r << 1;
            idx_r   <= len_r - LEN_W'(1);
          end else begin
            gap_r <= gap_r - GAP_W'(1);
          end
        end

        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          y       <= 1'b0;
          y_valid <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          y       <= 1'b0;
          y_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen -- self-checking bench for seq_gen.
// Two instances: dut0 with GAP_CYC=0 and dut2 with GAP_CYC=2. A reference
// model expands each request into per-cycle expected {busy,done,y_valid,y}
// entries queued at start time; they are popped and compared each cycle.
// Honours SEQ_GEN_PARITY_EN in the model.
// ---------------------------------------------------------------------------
module tb_seq_gen;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start2 = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [3:0] len_in = 4'd0;
  logic [3:0] rep_in = 4'd0;
  logic       y0, yv0, busy0, done0;
  logic       y2, yv2, busy2, done2;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];   // {busy, done, y_valid, y}

  always #5 clk = ~clk;

  seq_gen #(.PAT_W(8), .REP_W(4), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
    .y(y0), .y_valid(yv0), .busy(busy0), .done(done0)
  );

  seq_gen #(.PAT_W(8), .REP_W(4), .GAP_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort),
    .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
    .y(y2), .y_valid(yv2), .busy(busy2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected cycle stream from cycle 1 on, truncated by an abort, idle tail
  task automatic build_expect(input logic [7:0] p, input int l, input int r,
                              input int gap, input int abort_cyc);
    logic [7:0] sh;
    for (int k = 0; k <= r; k++) begin
      sh = p << (8 - l);
      for (int i = 0; i < l; i++) begin
        exp_q.push_back({1'b1, 1'b0, 1'b1, sh[7]});
        sh = sh << 1;
      end
`ifdef SEQ_GEN_PARITY_EN
      sh = p << (8 - l);
      exp_q.push_back({1'b1, 1'b0, 1'b1, ^sh});
`endif
      if (k < r) begin
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b1000);
      end
    end
    exp_q.push_back(4'b1100);
    if (abort_cyc > 0) begin
      while (exp_q.size() > abort_cyc) void'(exp_q.pop_back());
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic run_xfer(input string name, input bit use2, input logic [7:0] p,
                          input int l, input int r, input int abort_cyc,
                          input int restart_a, input int restart_b);
    logic [3:0] e;
    logic [3:0] obs;
    bit         st;
    int         cyc;
    exp_q.delete();
    build_expect(p, l, r, use2 ? 2 : 0, abort_cyc);
    pat_in = p;
    len_in = 4'(l);
    rep_in = 4'(r);
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0;
    start2 = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0) begin
      // inputs change freely while busy
      pat_in = 8'($urandom);
      len_in = 4'($urandom);
      rep_in = 4'($urandom);
      e   = exp_q.pop_front();
      obs = use2 ? {busy2, done2, yv2, y2} : {busy0, done0, yv0, y0};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: busy/done/valid/y got %b expected %b", name, cyc, obs, e);
      end
      abort = (cyc == abort_cyc);
      st = (cyc == restart_a) || (cyc == restart_b);
      if (st) len_in = 4'd4;
      if (use2) start2 = st; else start0 = st;
      step();
      cyc++;
    end
    abort  = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy0, done0, yv0, y0, busy2, done2, yv2, y2} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got %b expected 00000000",
               {busy0, done0, yv0, y0, busy2, done2, yv2, y2});
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_xfer("basic_1101", 1'b0, {4'b0000, SEQ_1101}, SEQ_1101_LEN, 0, 0, 0, 0);
  endtask

  task automatic test_gap();
    run_xfer("gap_rep2", 1'b1, 8'h0D, 4, 2, 0, 0, 0);
  endtask

  task automatic test_ignored_start();
    run_xfer("restart_busy", 1'b1, 8'h0D, 4, 2, 0, 2, 5);
    run_xfer("restart_done", 1'b0, 8'h0D, 4, 0, 0, 5, 0);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_rep2", 1'b0, 8'h0D, 4, 2, 0, 0, 0);
  endtask

  task automatic test_boundaries();
    run_xfer("len1_rep1", 1'b0, 8'h01, 1, 1, 0, 0, 0);
    run_xfer("len8", 1'b0, 8'h96, 8, 0, 0, 0, 0);
    run_xfer("len3_mask", 1'b0, 8'hF2, 3, 0, 0, 0, 0);
    run_xfer("len8_rep15_gap", 1'b1, 8'h3C, 8, 15, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_xfer("abort_shift", 1'b0, 8'hA5, 8, 0, 3, 0, 0);
    run_xfer("after_abort", 1'b0, 8'hA5, 8, 0, 0, 0, 0);
    run_xfer("abort_gap", 1'b1, 8'h0D, 4, 2, 6, 0, 0);
    // abort together with start in IDLE: start ignored
    pat_in = 8'h0D; len_in = 4'd4; rep_in = 4'd0;
    start0 = 1'b1; abort = 1'b1;
    step();
    start0 = 1'b0; abort = 1'b0;
    checks++;
    if ({busy0, yv0} !== 2'b00) begin
      failures++;
      $display("FAIL abort_start_idle: busy/valid got %b expected 00", {busy0, yv0});
    end
  endtask

  task automatic test_invalid_len();
    for (int n = 0; n < 2; n++) begin
      pat_in = 8'hFF;
      len_in = (n == 0) ? 4'd0 : 4'd9;
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if ({busy0, yv0} !== 2'b00) begin
          failures++;
          $display("FAIL invalid_len %0d: busy/valid got %b expected 00", len_in, {busy0, yv0});
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    pat_in = 8'h0D; len_in = 4'd4; rep_in = 4'd0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();             // cycle 2
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: busy got %b expected 1", busy0);
    end
    #2;
    rst = 1'b0;
    #1;                 // no clock edge in between
    checks++;
    if ({busy0, done0, yv0, y0} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_async: got %b expected 0000", {busy0, done0, yv0, y0});
    end
    step();
    rst = 1'b1;
    step();
    len_in = 4'd0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_len0: busy got %b expected 0", busy0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_ignored_start();
    test_back_to_back();
    test_boundaries();
    test_abort();
    test_invalid_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Bit-serial pattern transmitter. Counterpart of the 1101 sequence detector.
- Loads a pattern word of up to PAT_W bits and shifts it out MSB-first on a single serial line, one bit per clock.
- Supports a programmable repetition count and inter-repetition idle gaps.
- Drives the serial input y of downstream sequence detectors; also used as bench stimulus for them.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- REP_W, 4, width of the repetition-count field.
- GAP_CYC, 0, idle cycles (y=0, y_valid=0) inserted between repetitions; 0 means back-to-back.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel of an active transfer.
- pat_in  in  PAT_W  pattern; the low len_in bits are used.
- len_in  in  $clog2(PAT_W+1)  pattern length, valid range 1..PAT_W.
- rep_in  in  REP_W  extra repetitions; total sends = rep_in+1.
- y  out  1  serial data.
- y_valid  out  1  y carries a pattern bit this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst=0), asynchronous, takes effect immediately including mid-transfer: state=IDLE; y=0, y_valid=0, busy=0, done=0; shift register and counters cleared.
- All outputs are registered (Moore style); no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Start is accepted when start=1 and 1<=len_in<=PAT_W. On acceptance, capture pat_in, len_in, rep_in; set bit index = len-1 and rep counter = rep_in; go to SHIFT.
  - start with len_in=0 or len_in>PAT_W is ignored; remain in IDLE.
- SHIFT:
  - Each cycle: y = pat[idx], y_valid=1, idx decrements.
  - The first bit appears in the cycle after the start edge (latency 1).
  - On idx==0 with rep counter>0: decrement the counter and reload idx=len-1. Go to GAP if GAP_CYC>0, otherwise the next cycle is again SHIFT (no bubble).
  - On idx==0 with rep counter==0: go to DONE.
- GAP: y=0, y_valid=0 for exactly GAP_CYC cycles, then SHIFT.
- DONE: done=1, busy=1, y_valid=0 for one cycle, then IDLE. busy falls the cycle after done.
- start while busy is ignored and not queued. start asserted in the DONE cycle is also ignored.
- abort=1 in SHIFT, GAP or DONE: next state is IDLE, done not pulsed, y/y_valid=0 next cycle. abort has priority over all transitions. abort in IDLE has no effect, and abort+start together in IDLE means abort wins (start ignored).
- Cycle count for one transfer: (rep_in+1)*len + rep_in*GAP_CYC cycles with y_valid=1 or gap, plus 1 DONE cycle.
- The captured pattern is stable for the whole transfer; pat_in, len_in and rep_in may change freely while busy.

Optional Feature:
- SEQ_GEN_PARITY_EN defined: after the last data bit of every repetition, one extra SHIFT cycle emits the even-parity bit (XOR of the len transmitted bits) with y_valid=1, before GAP/next repetition/DONE. Transfer length grows by rep_in+1 cycles.
- SEQ_GEN_PARITY_EN undefined: no parity cycle; behaviour exactly as above.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, SHIFT, GAP, DONE);
  - localparam SEQ_1101 = 4'b1101 with SEQ_1101_LEN = 4, shared with the detector benches;
  - the LEN_W computation helper.
- No sub-module: a shift index, rep counter, gap counter and FSM fit in one module.

Test Plan:
- pat_in=8'h0D, len_in=4, rep_in=0, GAP_CYC=0, start pulse at cycle 0 -> y=1,1,0,1 with y_valid=1 in cycles 1-4; done=1 in cycle 5; busy=0 from cycle 6.
- Same pattern, rep_in=2, GAP_CYC=2 -> bursts 1101 at cycles 1-4, 7-10, 13-16; y_valid=0 in cycles 5-6 and 11-12; done at cycle 17.
- start re-pulsed at cycles 2 and 5 during the transfer above -> ignored; exactly one transfer; no second busy period.
- abort at cycle 3 of an 8-bit transfer (pat 8'hA5) -> y_valid=0 from cycle 4, busy=0 from cycle 4, done never asserted; a new start then works normally.
- rst driven low at cycle 2 mid-transfer -> y, y_valid, busy, done all 0 within the same cycle, without waiting for a clock edge; after release, start with len_in=0 is ignored and busy stays 0.
- With SEQ_GEN_PARITY_EN, pat 4'b1101, len 4, rep 0 -> y=1,1,0,1,1 (parity bit) in cycles 1-5; done at cycle 6. Connected to the 1101 detector, z fires once.
